lcd_bus_driver: RTL
===================

Name: lcd_bus_driver

Overview:
Physical-layer driver for the HD44780-style character LCD, directly downstream of the LCD interface sequencer. It accepts one byte plus an address/data select per request and produces the LCD's RS/RW/E/DB[7:0] strobes with correct setup, pulse, hold and execution-wait timing. It reports busy on busLock, which the sequencer polls before issuing its next byte. After reset it runs a fixed power-up initialisation sequence before accepting any request.

Parameters:
SETUP_CYC, 2, clk cycles RS/DB stable before E rises (≥1)
EN_HIGH_CYC, 12, clk cycles E held high (≥1; 12 = 240 ns at 50 MHz)
HOLD_CYC, 1, clk cycles RS/DB held after E falls (≥1)
CMD_WAIT_CYC, 2000, execution wait after a normal command or data byte (≥1)
CLEAR_WAIT_CYC, 80000, execution wait after clear (0x01) or home (0x02/0x03) (≥1)
POWERUP_CYC, 750000, wait after reset before the first init command (≥1)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
wrStb  input  1  single-cycle write request; sampled only when busLock=0 and initDone=1
addrOrData  input  1  0 = command/instruction (RS=0), 1 = data (RS=1)
lcdBus  input  8  byte to write
busLock  output  1  1 = busy, request ignored; 0 = ready
initDone  output  1  1 once the init sequence has completed; sticky until reset
lcdRs  output  1  LCD RS pin
lcdRw  output  1  LCD RW pin; constant 0
lcdEn  output  1  LCD E pin
lcdData  output  8  LCD DB[7:0]

Behaviour:
- Clock is clk. Reset is synchronous and active-high on rst.
- Reset values, all registered: busLock=1, initDone=0, lcdRs=0, lcdRw=0, lcdEn=0, lcdData=8'h00; FSM enters PWRUP; timer loads POWERUP_CYC.
- States: PWRUP, INIT_LOAD, IDLE, SETUP, PULSE, HOLD, WAIT.
- PWRUP: count POWERUP_CYC cycles, then go to INIT_LOAD.
- INIT_LOAD: load the next init ROM entry with RS=0, then go to SETUP. ROM order: 0x38 (8-bit, 2-line), 0x0C (display on), 0x01 (clear), 0x06 (entry increment).
- SETUP: lcdEn=0, lcdRs/lcdData driven from latched values; lasts SETUP_CYC cycles.
- PULSE: lcdEn=1; lasts EN_HIGH_CYC cycles.
- HOLD: lcdEn=0, data and RS unchanged; lasts HOLD_CYC cycles.
- WAIT: wait period is CLEAR_WAIT_CYC if RS=0 and byte ∈ {0x01, 0x02, 0x03}, else CMD_WAIT_CYC.
- Exit from WAIT:
  - More init entries remain: go to INIT_LOAD.
  - Last init entry done: initDone=1 and busLock=0 on the same edge, go to IDLE.
  - Otherwise: busLock=0, go to IDLE.
- IDLE: busLock=0. If wrStb=1 on edge N, latch lcdBus and addrOrData. At N: busLock=1, lcdRs/lcdData take the latched values, enter SETUP.
- Latency for an accepted request:
  - lcdEn rises at edge N+SETUP_CYC.
  - lcdEn falls at edge N+SETUP_CYC+EN_HIGH_CYC.
  - busLock falls at edge N+SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait.
- lcdData and lcdRs hold their last value in IDLE; they change only on acceptance.
- wrStb while busLock=1 (including all of init) is ignored: no queueing, no latching.
- Inputs lcdBus/addrOrData changing after acceptance have no effect.
- rst asserted in any state, including mid-pulse: next edge forces lcdEn=0 and all reset values; init re-runs in full.
- Timer is a single down-counter, width $clog2(max parameter + 1). It loads (duration−1) on state entry; the state exits when the count is 0.

Decomposition:
- lcd_pkg holds:
  - state enum
  - init ROM depth (4) and contents
  - command constants CMD_CLEAR=8'h01, CMD_HOME=8'h02, CMD_FUNC_SET=8'h38, CMD_DISP_ON=8'h0C, CMD_ENTRY=8'h06
  - function is_long_cmd(rs, byte)
- One sub-module, lcd_delay_timer:
  - parameterised width
  - load/value inputs
  - outputs zero flag
  - synchronous active-high reset

Test Plan (bench params SETUP=2, EN_HIGH=12, HOLD=1, CMD_WAIT=20, CLEAR_WAIT=80, POWERUP=100):
- Reset release → busLock=1 for 100 + 3×(15+20) + (15+80) = 300 cycles. Four E pulses with lcdRs=0 and lcdData 0x38, 0x0C, 0x01, 0x06, each E high exactly 12 cycles. Then initDone=1, busLock=0.
- After init, wrStb with addrOrData=1, lcdBus=0x41 → next edge busLock=1, lcdRs=1, lcdData=0x41. lcdEn rises 2 cycles later and stays high 12 cycles. busLock falls 35 cycles after acceptance.
- Command 0x01 with addrOrData=0 → busLock held 95 cycles. Command 0x80 → busLock held 35 cycles.
- wrStb pulsed with 0x55 during init and again mid-write → no extra E pulse; lcdData never shows 0x55.
- rst asserted during PULSE of a data write → lcdEn=0 on the next edge, initDone=0, busLock=1. The full 300-cycle init repeats.
- Change lcdBus to 0xFF one cycle after accepting 0x30 → lcdData stays 0x30 through HOLD. lcdRw is 0 throughout.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types, command constants and init ROM for the HD44780 bus driver.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWRUP,
    ST_INIT_LOAD,
    ST_IDLE,
    ST_SETUP,
    ST_PULSE,
    ST_HOLD,
    ST_WAIT
  } lcd_state_e;

  localparam int unsigned INIT_DEPTH = 4;
  localparam int unsigned INIT_IDX_W = $clog2(INIT_DEPTH);

  localparam logic [7:0] CMD_CLEAR    = 8'h01;
  localparam logic [7:0] CMD_HOME     = 8'h02;
  localparam logic [7:0] CMD_FUNC_SET = 8'h38;
  localparam logic [7:0] CMD_DISP_ON  = 8'h0C;
  localparam logic [7:0] CMD_ENTRY    = 8'h06;

  function automatic logic [7:0] init_rom(input logic [INIT_IDX_W-1:0] idx);
    logic [7:0] b;
    unique case (idx)
      2'd0:    b = CMD_FUNC_SET;
      2'd1:    b = CMD_DISP_ON;
      2'd2:    b = CMD_CLEAR;
      default: b = CMD_ENTRY;
    endcase
    return b;
  endfunction

  // Clear and both home encodings (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] b);
    return !rs && ((b == CMD_CLEAR) || (b == CMD_HOME) || (b == 8'h03));
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

  function automatic int unsigned sub_sat(input int unsigned d, input int unsigned k);
    return (d > k) ? d - k : 0;
  endfunction

endpackage

// File: rtl/lcd_delay_timer.sv
// Loadable down-counter; zero_o flags expiry of the current interval.
module lcd_delay_timer #(
  parameter int unsigned      WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] value_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = value_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= RESET_VALUE;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/lcd_bus_driver.sv
// HD44780 physical-layer driver: power-up init, then one byte per request
// with setup / E-pulse / hold / execution-wait sequencing.
module lcd_bus_driver
  import lcd_pkg::*;
#(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned EN_HIGH_CYC    = 12,
  parameter int unsigned HOLD_CYC       = 1,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 80000,
  parameter int unsigned POWERUP_CYC    = 750000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wrStb,
  input  logic       addrOrData,
  input  logic [7:0] lcdBus,
  output logic       busLock,
  output logic       initDone,
  output logic       lcdRs,
  output logic       lcdRw,
  output logic       lcdEn,
  output logic [7:0] lcdData
);

  localparam int unsigned MAX_CYC = max_u(max_u(max_u(SETUP_CYC, EN_HIGH_CYC), max_u(HOLD_CYC, CMD_WAIT_CYC)),
                                          max_u(CLEAR_WAIT_CYC, POWERUP_CYC));
  localparam int unsigned TW = $clog2(MAX_CYC + 1);

  // Intervals followed by the one-cycle INIT_LOAD step are loaded one shorter,
  // so the init sequence spacing equals the nominal durations.
  localparam logic [TW-1:0] LD_PWRUP      = TW'(sub_sat(POWERUP_CYC, 2));
  localparam logic [TW-1:0] LD_SETUP      = TW'(sub_sat(SETUP_CYC, 1));
  localparam logic [TW-1:0] LD_PULSE      = TW'(sub_sat(EN_HIGH_CYC, 1));
  localparam logic [TW-1:0] LD_HOLD       = TW'(sub_sat(HOLD_CYC, 1));
  localparam logic [TW-1:0] LD_CMD        = TW'(sub_sat(CMD_WAIT_CYC, 1));
  localparam logic [TW-1:0] LD_CMD_INIT   = TW'(sub_sat(CMD_WAIT_CYC, 2));
  localparam logic [TW-1:0] LD_CLEAR      = TW'(sub_sat(CLEAR_WAIT_CYC, 1));
  localparam logic [TW-1:0] LD_CLEAR_INIT = TW'(sub_sat(CLEAR_WAIT_CYC, 2));

  localparam logic [INIT_IDX_W-1:0] LAST_IDX = INIT_IDX_W'(INIT_DEPTH - 1);

  lcd_state_e             state_q;
  logic                   busLock_q;
  logic                   initDone_q;
  logic                   rs_q;
  logic                   en_q;
  logic [7:0]             data_q;
  logic [INIT_IDX_W-1:0]  rom_idx_q;

  logic                   tmr_load;
  logic [TW-1:0]          tmr_value;
  logic                   tmr_zero;
  logic                   more_init;

  assign more_init = !initDone_q && (rom_idx_q != LAST_IDX);

  lcd_delay_timer #(
    .WIDTH       (TW),
    .RESET_VALUE (LD_PWRUP)
  ) u_timer (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (tmr_load),
    .value_i (tmr_value),
    .zero_o  (tmr_zero)
  );

  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    unique case (state_q)
      ST_INIT_LOAD: begin
        tmr_load  = 1'b1;
        tmr_value = LD_SETUP;
      end
      ST_IDLE: begin
        if (wrStb) begin
          tmr_load  = 1'b1;
          tmr_value = LD_SETUP;
        end
      end
      ST_SETUP: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = LD_PULSE;
        end
      end
      ST_PULSE: begin
        if (tmr_zero) begin
          tmr_load  = 1'b1;
          tmr_value = LD_HOLD;
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          tmr_load = 1'b1;
          if (is_long_cmd(rs_q, data_q)) begin
            tmr_value = more_init ? LD_CLEAR_INIT : LD_CLEAR;
          end else begin
            tmr_value = more_init ? LD_CMD_INIT : LD_CMD;
          end
        end
      end
      default: begin
        tmr_load  = 1'b0;
        tmr_value = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_PWRUP;
      busLock_q  <= 1'b1;
      initDone_q <= 1'b0;
      rs_q       <= 1'b0;
      en_q       <= 1'b0;
      data_q     <= '0;
      rom_idx_q  <= '0;
    end else begin
      unique case (state_q)
        ST_PWRUP: begin
          if (tmr_zero) state_q <= ST_INIT_LOAD;
        end
        ST_INIT_LOAD: begin
          rs_q    <= 1'b0;
          data_q  <= init_rom(rom_idx_q);
          state_q <= ST_SETUP;
        end
        ST_IDLE: begin
          if (wrStb) begin
            busLock_q <= 1'b1;
            rs_q      <= addrOrData;
            data_q    <= lcdBus;
            state_q   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            en_q    <= 1'b1;
            state_q <= ST_PULSE;
          end
        end
        ST_PULSE: begin
          if (tmr_zero) begin
            en_q    <= 1'b0;
            state_q <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (tmr_zero) begin
            if (more_init) begin
              rom_idx_q <= rom_idx_q + 1'b1;
              state_q   <= ST_INIT_LOAD;
            end else begin
              initDone_q <= 1'b1;
              busLock_q  <= 1'b0;
              state_q    <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q   <= ST_PWRUP;
          busLock_q <= 1'b1;
          en_q      <= 1'b0;
        end
      endcase
    end
  end

  assign busLock  = busLock_q;
  assign initDone = initDone_q;
  assign lcdRs    = rs_q;
  assign lcdRw    = 1'b0;
  assign lcdEn    = en_q;
  assign lcdData  = data_q;

endmodule
